// File: rtl/top_level_pio_pkg.sv
// Shared definitions for the PIO slaves on the system interconnect:
// register addresses, edge-capture polarity encodings and the edge filter.
package top_level_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE    = 2'd3;

  localparam int unsigned EDGE_RISE = 32'd0;
  localparam int unsigned EDGE_FALL = 32'd1;
  localparam int unsigned EDGE_ANY  = 32'd2;

  function automatic logic edge_hit(input logic cur, input logic prev,
                                    input int unsigned edge_type);
    logic hit;
    case (edge_type)
      EDGE_RISE: hit = cur & ~prev;
      EDGE_FALL: hit = ~cur & prev;
      EDGE_ANY:  hit = cur ^ prev;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/top_level_debounce_bit.sv
// One input bit: 2-FF synchroniser followed by a stability counter that only
// accepts a new level after DEBOUNCE_CYCLES consecutive differing samples.
module top_level_debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd500000,
  parameter logic        IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic stable
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic             sync1_r;
  logic             sync2_r;
  logic [CNT_W-1:0] cnt_r;

  // synchroniser, qualification counter and accepted level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= IDLE_LEVEL;
      sync2_r <= IDLE_LEVEL;
      stable  <= IDLE_LEVEL;
      cnt_r   <= '0;
    end else begin
      sync1_r <= in_bit;
      sync2_r <= sync1_r;
      if (sync2_r == stable) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_MAX) begin
        stable <= sync2_r;
        cnt_r  <= '0;
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
    end
  end

endmodule

// File: rtl/top_level_key_pio.sv
// Avalon-MM input PIO for the DE2 pushbuttons: debounced DATA, IRQMASK and
// EDGECAPTURE registers with a level interrupt to the processor.
module top_level_key_pio
  import top_level_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 32'd4,
  parameter int unsigned DEBOUNCE_CYCLES = 32'd500000,
  parameter int unsigned EDGE_TYPE       = 32'd1,
  parameter logic        IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] stable_s;
  logic [WIDTH-1:0] stable_d_r;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] edge_cap_r;
  logic [WIDTH-1:0] irq_mask_r;
  logic [31:0]      rd_mux_s;
  logic             rd_s;
  logic             wr_s;
  logic             unused_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    top_level_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_LEVEL     (IDLE_LEVEL)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .in_bit(in_port[i]),
      .stable(stable_s[i])
    );
  end

  assign rd_s     = chipselect & ~read_n;
  assign wr_s     = chipselect & ~write_n;
  assign unused_s = ^{1'b0, writedata};

  // edge filter, capture-clear mask and read multiplexer
  always_comb begin
    edge_s   = '0;
    clr_s    = '0;
    rd_mux_s = 32'd0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_s[i] = edge_hit(stable_s[i], stable_d_r[i], EDGE_TYPE);
    end
    if (wr_s && (address == PIO_ADDR_EDGE)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = '0;
    end
    case (address)
      PIO_ADDR_DATA:    rd_mux_s[WIDTH-1:0] = stable_s;
      PIO_ADDR_DIR:     rd_mux_s = 32'd0;
      PIO_ADDR_IRQMASK: rd_mux_s[WIDTH-1:0] = irq_mask_r;
      PIO_ADDR_EDGE:    rd_mux_s[WIDTH-1:0] = edge_cap_r;
      default:          rd_mux_s = 32'd0;
    endcase
  end

  // register file and read-data register; a new edge beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d_r <= {WIDTH{IDLE_LEVEL}};
      edge_cap_r <= '0;
      irq_mask_r <= '0;
      readdata   <= 32'd0;
    end else begin
      stable_d_r <= stable_s;
      edge_cap_r <= (edge_cap_r & ~clr_s) | edge_s;
      if (wr_s && (address == PIO_ADDR_IRQMASK)) begin
        irq_mask_r <= writedata[WIDTH-1:0];
      end
      if (rd_s) begin
        readdata <= rd_mux_s;
      end
    end
  end

  assign irq = |(edge_cap_r & irq_mask_r);

endmodule
